mor1kx_decode_execute_cappuccino: RTL and testbench
===================================================

MOR1KX_DECODE_EXECUTE_CAPPUCCINO -- requirements
Module: mor1kx_decode_execute_cappuccino

Interface
REQ-001 SHALL have parameter OPTION_OPERAND_WIDTH, default 32: datapath width.
REQ-002 SHALL have parameter OPTION_RESET_PC, default 32'h00000100: pc_execute_o reset value.
REQ-003 SHALL have parameter OPTION_RF_ADDR_WIDTH, default 5: register-file address width.
REQ-004 SHALL have ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- padv_i  in  1  advance decode->execute.
- pipeline_flush_i  in  1  flush request.
- du_stall_i  in  1  debug-unit stall.
- decode_valid_i  in  1  decode holds a real instruction.
- decode_op_lsu_load_i, decode_op_lsu_store_i, decode_op_mfspr_i, decode_op_mtspr_i, decode_op_jal_i, decode_op_jr_i, decode_op_rfe_i, decode_op_branch_i  in  1 each  decoded op class.
- decode_rf_wb_i  in  1  decode writes the register file.
- decode_rfd_adr_i, decode_rfa_adr_i, decode_rfb_adr_i  in  OPTION_RF_ADDR_WIDTH  destination and source addresses.
- decode_rfa_used_i, decode_rfb_used_i  in  1 each  source operand read.
- decode_imm_i  in  OPTION_OPERAND_WIDTH  immediate.
- decode_pc_i  in  OPTION_OPERAND_WIDTH  decode PC.
- decode_except_ibus_err_i, decode_except_illegal_i, decode_except_syscall_i, decode_except_trap_i  in  1 each  exceptions.
- execute_op_*_o  out  1 each  registered copies of the eight op flags.
- execute_rf_wb_o  out  1  registered write enable.
- execute_rfd_adr_o  out  OPTION_RF_ADDR_WIDTH  registered destination.
- execute_imm_o  out  OPTION_OPERAND_WIDTH  registered immediate.
- pc_execute_o  out  OPTION_OPERAND_WIDTH  execute PC.
- execute_except_*_o  out  1 each  registered exceptions.
- execute_bubble_o  out  1  execute holds a bubble.
- decode_stall_o  out  1  load-use hazard (combinational).
- execute_delay_slot_o  out  1  delay-slot flag (REQ-019).

Function
REQ-005 decode_stall_o SHALL equal execute_op_lsu_load_o & execute_rf_wb_o & ((decode_rfa_used_i & decode_rfa_adr_i==execute_rfd_adr_o) | (decode_rfb_used_i & decode_rfb_adr_i==execute_rfd_adr_o)).
- decode_stall_o SHALL NOT depend on padv_i.
REQ-006 Priority per cycle: flush, then advance, then hold.
- Flush is pipeline_flush_i & !du_stall_i.
REQ-007 On flush, all op flags, execute_rf_wb_o and exception outputs SHALL be 0 and execute_bubble_o SHALL be 1 next cycle, regardless of padv_i.
REQ-008 On padv_i with bubble condition (!decode_valid_i | decode_stall_o):
- op flags, rf_wb and exceptions SHALL load 0.
- execute_bubble_o SHALL load 1.
- pc_execute_o SHALL hold.
REQ-009 On padv_i without bubble condition:
- all decode_* fields SHALL load, with 1-cycle latency.
- execute_bubble_o SHALL load 0.
- pc_execute_o SHALL load decode_pc_i.
REQ-010 Without padv_i and without flush, all registered outputs SHALL hold.
REQ-011 execute_imm_o and execute_rfd_adr_o SHALL load on every padv_i, bubble or not, and SHALL have no reset.
REQ-012 Flush with du_stall_i=1 SHALL be ignored; the stage holds or advances per REQ-008/009.
REQ-013 Hazard persists across consecutive padv_i: one bubble SHALL be inserted per padv_i until the load leaves execute.

Reset
REQ-014 While rst_n=0, asynchronously:
- op flags, rf_wb and exceptions SHALL be 0.
- execute_bubble_o SHALL be 1.
- pc_execute_o SHALL be OPTION_RESET_PC.
- execute_delay_slot_o SHALL be 0.
REQ-015 Reset asserted mid-stall SHALL discard the held instruction; first padv_i after release behaves per REQ-008/009.

Configuration
REQ-016 Macro MOR1KX_DELAY_SLOT_EN SHALL select delay-slot tracking.
REQ-017 With MOR1KX_DELAY_SLOT_EN defined, a 1-bit register branch_in_exec SHALL track branches:
- set when a non-bubble instruction with op_branch|op_jal|op_jr advances.
- cleared when any other non-bubble instruction advances.
- held on bubbles.
- cleared on flush and reset.
REQ-018 With MOR1KX_DELAY_SLOT_EN defined, execute_delay_slot_o SHALL load branch_in_exec on each non-bubble advance, and SHALL clear on flush and on bubble advance.
REQ-019 Without MOR1KX_DELAY_SLOT_EN, execute_delay_slot_o SHALL be constant 0 and no tracking register SHALL exist.

Structure
REQ-020 Op-flag index constants and the reset-PC default SHALL live in shared package mor1kx_pipe_pkg.
REQ-021 Sub-module mor1kx_hazard_detect SHALL produce decode_stall_o; all remaining logic is flat.

Verification
REQ-022 Bench SHALL cover these scenarios:
- Reset: rst_n low with padv_i=1 -> bubble=1, pc_execute_o=0x100, all ops 0.
- Load-use: execute load rfd=5, rf_wb=1; decode rfa=5 used, padv_i=1 -> decode_stall_o=1; next cycle bubble=1, load flag 0, pc held.
- Normal advance: decode pc=0x200, rfd=3, imm=0xFFFF, padv_i=1 -> next cycle pc_execute_o=0x200, rfd=3, imm=0xFFFF, bubble=0.
- Flush vs advance: flush=1, du_stall=0, padv_i=1 -> ops cleared, bubble=1.
- Debug stall: flush=1, du_stall=1, padv_i=0 -> outputs unchanged.
- Delay slot (macro on): advance jal, then add -> add has execute_delay_slot_o=1; next instruction has 0.

Source files
------------

// File: rtl/mor1kx_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mor1kx_pipe_pkg (package)
// Purpose  : Shared constants for the cappuccino decode->execute stage:
//            bit positions of the packed op-class and exception vectors,
//            the default reset PC, and a helper that spots control transfers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mor1kx_pipe_pkg;

  // Bit positions inside the packed op-class vector.
  localparam int OP_LSU_LOAD  = 0;
  localparam int OP_LSU_STORE = 1;
  localparam int OP_MFSPR     = 2;
  localparam int OP_MTSPR     = 3;
  localparam int OP_JAL       = 4;
  localparam int OP_JR        = 5;
  localparam int OP_RFE       = 6;
  localparam int OP_BRANCH    = 7;
  localparam int NUM_OPS      = 8;

  // Bit positions inside the packed exception vector.
  localparam int EXC_IBUS_ERR = 0;
  localparam int EXC_ILLEGAL  = 1;
  localparam int EXC_SYSCALL  = 2;
  localparam int EXC_TRAP     = 3;
  localparam int NUM_EXC      = 4;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0100;

  // True for any op that opens a delay slot behind it.
  function automatic logic is_control_transfer(input logic [NUM_OPS-1:0] ops);
    return ops[OP_BRANCH] | ops[OP_JAL] | ops[OP_JR];
  endfunction

endpackage : mor1kx_pipe_pkg
`default_nettype wire

// File: rtl/mor1kx_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module   : mor1kx_hazard_detect
// Purpose  : Load-use hazard detector. Flags a stall when the instruction in
//            execute is a register-writing load and the instruction in decode
//            reads that destination through either source port. Purely
//            combinational and independent of pipeline advance.
// Ports    : execute_op_lsu_load / execute_rf_wb / execute_rfd_adr - execute
//            side load, write enable and destination; decode_rf{a,b}_adr /
//            decode_rf{a,b}_used - decode side source operands;
//            decode_stall - hazard present.
// Revision : 1.0 - initial release
// ============================================================================
module mor1kx_hazard_detect #(
  parameter int RF_ADDR_WIDTH = 5
) (
  input  logic                     execute_op_lsu_load,
  input  logic                     execute_rf_wb,
  input  logic [RF_ADDR_WIDTH-1:0] execute_rfd_adr,
  input  logic [RF_ADDR_WIDTH-1:0] decode_rfa_adr,
  input  logic [RF_ADDR_WIDTH-1:0] decode_rfb_adr,
  input  logic                     decode_rfa_used,
  input  logic                     decode_rfb_used,
  output logic                     decode_stall
);

  logic rfa_hit;
  logic rfb_hit;

  assign rfa_hit = decode_rfa_used & (decode_rfa_adr == execute_rfd_adr);
  assign rfb_hit = decode_rfb_used & (decode_rfb_adr == execute_rfd_adr);

  assign decode_stall = execute_op_lsu_load & execute_rf_wb & (rfa_hit | rfb_hit);

endmodule : mor1kx_hazard_detect
`default_nettype wire

// File: rtl/mor1kx_decode_execute_cappuccino.sv
`default_nettype none
// ============================================================================
// Module   : mor1kx_decode_execute_cappuccino
// Purpose  : Decode->execute pipeline register of the cappuccino pipeline.
//            Per cycle: flush (unless the debug unit stalls) beats advance,
//            advance beats hold. On advance a bubble is inserted when decode
//            holds no instruction or a load-use hazard exists.
// Options  : MOR1KX_DELAY_SLOT_EN - when defined, tracks whether the
//            instruction in execute sits in a branch delay slot; otherwise
//            execute_delay_slot_o is tied to 0.
// Ports    : clk, rst_n (async, active-low); padv_i, pipeline_flush_i,
//            du_stall_i - pipeline control; decode_* - decoded instruction;
//            execute_* / pc_execute_o - registered instruction for execute;
//            execute_bubble_o - execute holds no instruction;
//            decode_stall_o - combinational load-use hazard;
//            execute_delay_slot_o - delay-slot flag.
// Revision : 1.0 - initial release
// ============================================================================
module mor1kx_decode_execute_cappuccino
  import mor1kx_pipe_pkg::*;
#(
  parameter int          OPTION_OPERAND_WIDTH = 32,
  parameter logic [31:0] OPTION_RESET_PC      = DEFAULT_RESET_PC,
  parameter int          OPTION_RF_ADDR_WIDTH = 5
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            padv_i,
  input  logic                            pipeline_flush_i,
  input  logic                            du_stall_i,
  input  logic                            decode_valid_i,
  input  logic                            decode_op_lsu_load_i,
  input  logic                            decode_op_lsu_store_i,
  input  logic                            decode_op_mfspr_i,
  input  logic                            decode_op_mtspr_i,
  input  logic                            decode_op_jal_i,
  input  logic                            decode_op_jr_i,
  input  logic                            decode_op_rfe_i,
  input  logic                            decode_op_branch_i,
  input  logic                            decode_rf_wb_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] decode_rfd_adr_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] decode_rfa_adr_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] decode_rfb_adr_i,
  input  logic                            decode_rfa_used_i,
  input  logic                            decode_rfb_used_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] decode_imm_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] decode_pc_i,
  input  logic                            decode_except_ibus_err_i,
  input  logic                            decode_except_illegal_i,
  input  logic                            decode_except_syscall_i,
  input  logic                            decode_except_trap_i,
  output logic                            execute_op_lsu_load_o,
  output logic                            execute_op_lsu_store_o,
  output logic                            execute_op_mfspr_o,
  output logic                            execute_op_mtspr_o,
  output logic                            execute_op_jal_o,
  output logic                            execute_op_jr_o,
  output logic                            execute_op_rfe_o,
  output logic                            execute_op_branch_o,
  output logic                            execute_rf_wb_o,
  output logic [OPTION_RF_ADDR_WIDTH-1:0] execute_rfd_adr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] execute_imm_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] pc_execute_o,
  output logic                            execute_except_ibus_err_o,
  output logic                            execute_except_illegal_o,
  output logic                            execute_except_syscall_o,
  output logic                            execute_except_trap_o,
  output logic                            execute_bubble_o,
  output logic                            decode_stall_o,
  output logic                            execute_delay_slot_o
);

  localparam logic [OPTION_OPERAND_WIDTH-1:0] RESET_PC_W =
    OPTION_OPERAND_WIDTH'(OPTION_RESET_PC);

  logic [NUM_OPS-1:0]              decode_ops;
  logic [NUM_OPS-1:0]              ops_q;
  logic [NUM_EXC-1:0]              decode_exc;
  logic [NUM_EXC-1:0]              exc_q;
  logic                            rf_wb_q;
  logic                            bubble_q;
  logic [OPTION_OPERAND_WIDTH-1:0] pc_q;
  logic [OPTION_OPERAND_WIDTH-1:0] imm_q;
  logic [OPTION_RF_ADDR_WIDTH-1:0] rfd_q;
  logic                            flush;
  logic                            insert_bubble;
  logic                            advance_real;

  // Pack the decoded op classes and exceptions so the register logic below
  // treats them as single vectors.
  always_comb begin
    decode_ops               = '0;
    decode_ops[OP_LSU_LOAD]  = decode_op_lsu_load_i;
    decode_ops[OP_LSU_STORE] = decode_op_lsu_store_i;
    decode_ops[OP_MFSPR]     = decode_op_mfspr_i;
    decode_ops[OP_MTSPR]     = decode_op_mtspr_i;
    decode_ops[OP_JAL]       = decode_op_jal_i;
    decode_ops[OP_JR]        = decode_op_jr_i;
    decode_ops[OP_RFE]       = decode_op_rfe_i;
    decode_ops[OP_BRANCH]    = decode_op_branch_i;

    decode_exc               = '0;
    decode_exc[EXC_IBUS_ERR] = decode_except_ibus_err_i;
    decode_exc[EXC_ILLEGAL]  = decode_except_illegal_i;
    decode_exc[EXC_SYSCALL]  = decode_except_syscall_i;
    decode_exc[EXC_TRAP]     = decode_except_trap_i;
  end

  mor1kx_hazard_detect #(
    .RF_ADDR_WIDTH (OPTION_RF_ADDR_WIDTH)
  ) u_hazard_detect (
    .execute_op_lsu_load (ops_q[OP_LSU_LOAD]),
    .execute_rf_wb       (rf_wb_q),
    .execute_rfd_adr     (rfd_q),
    .decode_rfa_adr      (decode_rfa_adr_i),
    .decode_rfb_adr      (decode_rfb_adr_i),
    .decode_rfa_used     (decode_rfa_used_i),
    .decode_rfb_used     (decode_rfb_used_i),
    .decode_stall        (decode_stall_o)
  );

  // While the debug unit holds the pipeline a flush request is not honoured.
  assign flush         = pipeline_flush_i & ~du_stall_i;
  assign insert_bubble = ~decode_valid_i | decode_stall_o;
  assign advance_real  = ~flush & padv_i & ~insert_bubble;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_q    <= '0;
      exc_q    <= '0;
      rf_wb_q  <= 1'b0;
      bubble_q <= 1'b1;
      pc_q     <= RESET_PC_W;
    end else if (flush) begin
      ops_q    <= '0;
      exc_q    <= '0;
      rf_wb_q  <= 1'b0;
      bubble_q <= 1'b1;
    end else if (padv_i) begin
      if (insert_bubble) begin
        // PC is kept so execute still reports the last real instruction.
        ops_q    <= '0;
        exc_q    <= '0;
        rf_wb_q  <= 1'b0;
        bubble_q <= 1'b1;
      end else begin
        ops_q    <= decode_ops;
        exc_q    <= decode_exc;
        rf_wb_q  <= decode_rf_wb_i;
        bubble_q <= 1'b0;
        pc_q     <= decode_pc_i;
      end
    end
  end

  // Immediate and destination are qualified downstream by the op flags and
  // rf_wb, so they need no reset and simply follow every advance.
  always_ff @(posedge clk) begin
    if (padv_i) begin
      imm_q <= decode_imm_i;
      rfd_q <= decode_rfd_adr_i;
    end
  end

`ifdef MOR1KX_DELAY_SLOT_EN
  logic branch_in_exec;
  logic delay_slot_q;

  // branch_in_exec remembers whether the last real instruction to enter
  // execute was a control transfer; bubbles leave it alone so a stalled
  // delay-slot instruction is still recognised when it finally advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_in_exec <= 1'b0;
      delay_slot_q   <= 1'b0;
    end else if (flush) begin
      branch_in_exec <= 1'b0;
      delay_slot_q   <= 1'b0;
    end else if (padv_i) begin
      if (advance_real) begin
        branch_in_exec <= is_control_transfer(decode_ops);
        delay_slot_q   <= branch_in_exec;
      end else begin
        delay_slot_q   <= 1'b0;
      end
    end
  end

  assign execute_delay_slot_o = delay_slot_q;
`else
  assign execute_delay_slot_o = 1'b0;
`endif

  assign execute_op_lsu_load_o     = ops_q[OP_LSU_LOAD];
  assign execute_op_lsu_store_o    = ops_q[OP_LSU_STORE];
  assign execute_op_mfspr_o        = ops_q[OP_MFSPR];
  assign execute_op_mtspr_o        = ops_q[OP_MTSPR];
  assign execute_op_jal_o          = ops_q[OP_JAL];
  assign execute_op_jr_o           = ops_q[OP_JR];
  assign execute_op_rfe_o          = ops_q[OP_RFE];
  assign execute_op_branch_o       = ops_q[OP_BRANCH];
  assign execute_except_ibus_err_o = exc_q[EXC_IBUS_ERR];
  assign execute_except_illegal_o  = exc_q[EXC_ILLEGAL];
  assign execute_except_syscall_o  = exc_q[EXC_SYSCALL];
  assign execute_except_trap_o     = exc_q[EXC_TRAP];
  assign execute_rf_wb_o           = rf_wb_q;
  assign execute_bubble_o          = bubble_q;
  assign execute_rfd_adr_o         = rfd_q;
  assign execute_imm_o             = imm_q;
  assign pc_execute_o              = pc_q;

  // advance_real only feeds the optional delay-slot logic.
  logic unused_ok;
  assign unused_ok = advance_real;

endmodule : mor1kx_decode_execute_cappuccino
`default_nettype wire

// File: tb/tb_mor1kx_decode_execute_cappuccino.sv
`default_nettype none
// ============================================================================
// Module   : tb_mor1kx_decode_execute_cappuccino
// Purpose  : Self-checking bench for the decode->execute stage. A table of
//            per-cycle vectors with hand-computed expectations, followed by
//            hand-written sequences for asynchronous reset during a stall and
//            delay-slot tracking (MOR1KX_DELAY_SLOT_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mor1kx_decode_execute_cappuccino;

`ifdef MOR1KX_DELAY_SLOT_EN
  localparam logic DS_EN = 1'b1;
`else
  localparam logic DS_EN = 1'b0;
`endif

  // Op vector bit order: 0 load,1 store,2 mfspr,3 mtspr,4 jal,5 jr,6 rfe,7 branch
  // Exception order:     0 ibus_err,1 illegal,2 syscall,3 trap
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        padv = 1'b0, flush = 1'b0, du = 1'b0, valid = 1'b0;
  logic [7:0]  ops = '0;
  logic        rf_wb = 1'b0;
  logic [4:0]  rfd = '0, rfa = '0, rfb = '0;
  logic        rfa_u = 1'b0, rfb_u = 1'b0;
  logic [31:0] imm = '0, pc = '0;
  logic [3:0]  exc = '0;

  logic [7:0]  q_ops;
  logic [3:0]  q_exc;
  logic        q_wb, q_bub, q_stall, q_ds;
  logic [4:0]  q_rfd;
  logic [31:0] q_imm, q_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mor1kx_decode_execute_cappuccino dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .padv_i                    (padv),
    .pipeline_flush_i          (flush),
    .du_stall_i                (du),
    .decode_valid_i            (valid),
    .decode_op_lsu_load_i      (ops[0]),
    .decode_op_lsu_store_i     (ops[1]),
    .decode_op_mfspr_i         (ops[2]),
    .decode_op_mtspr_i         (ops[3]),
    .decode_op_jal_i           (ops[4]),
    .decode_op_jr_i            (ops[5]),
    .decode_op_rfe_i           (ops[6]),
    .decode_op_branch_i        (ops[7]),
    .decode_rf_wb_i            (rf_wb),
    .decode_rfd_adr_i          (rfd),
    .decode_rfa_adr_i          (rfa),
    .decode_rfb_adr_i          (rfb),
    .decode_rfa_used_i         (rfa_u),
    .decode_rfb_used_i         (rfb_u),
    .decode_imm_i              (imm),
    .decode_pc_i               (pc),
    .decode_except_ibus_err_i  (exc[0]),
    .decode_except_illegal_i   (exc[1]),
    .decode_except_syscall_i   (exc[2]),
    .decode_except_trap_i      (exc[3]),
    .execute_op_lsu_load_o     (q_ops[0]),
    .execute_op_lsu_store_o    (q_ops[1]),
    .execute_op_mfspr_o        (q_ops[2]),
    .execute_op_mtspr_o        (q_ops[3]),
    .execute_op_jal_o          (q_ops[4]),
    .execute_op_jr_o           (q_ops[5]),
    .execute_op_rfe_o          (q_ops[6]),
    .execute_op_branch_o       (q_ops[7]),
    .execute_rf_wb_o           (q_wb),
    .execute_rfd_adr_o         (q_rfd),
    .execute_imm_o             (q_imm),
    .pc_execute_o              (q_pc),
    .execute_except_ibus_err_o (q_exc[0]),
    .execute_except_illegal_o  (q_exc[1]),
    .execute_except_syscall_o  (q_exc[2]),
    .execute_except_trap_o     (q_exc[3]),
    .execute_bubble_o          (q_bub),
    .decode_stall_o            (q_stall),
    .execute_delay_slot_o      (q_ds)
  );

  typedef struct {
    logic        padv, flush, du, valid;
    logic [7:0]  ops;
    logic        rf_wb;
    logic [4:0]  rfd, rfa, rfb;
    logic        rfa_u, rfb_u;
    logic [31:0] imm, pc;
    logic [3:0]  exc;
    // expectations
    logic        e_stall;   // before the edge
    logic [7:0]  e_ops;     // after the edge
    logic        e_wb;
    logic [3:0]  e_exc;
    logic        e_bub;
    logic        chk_data;  // compare rfd/imm/pc
    logic [4:0]  e_rfd;
    logic [31:0] e_imm, e_pc;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(
    input logic pv, input logic fl, input logic d, input logic v,
    input logic [7:0] o, input logic wb, input logic [4:0] dd,
    input logic [4:0] a, input logic au, input logic [4:0] b, input logic bu,
    input logic [31:0] im, input logic [31:0] p, input logic [3:0] ex,
    input logic es, input logic [7:0] eo, input logic ew, input logic [3:0] ee,
    input logic eb, input logic cd, input logic [4:0] erd,
    input logic [31:0] eim, input logic [31:0] ep);
    vec_t r;
    r.padv = pv; r.flush = fl; r.du = d; r.valid = v; r.ops = o; r.rf_wb = wb;
    r.rfd = dd; r.rfa = a; r.rfa_u = au; r.rfb = b; r.rfb_u = bu;
    r.imm = im; r.pc = p; r.exc = ex;
    r.e_stall = es; r.e_ops = eo; r.e_wb = ew; r.e_exc = ee; r.e_bub = eb;
    r.chk_data = cd; r.e_rfd = erd; r.e_imm = eim; r.e_pc = ep;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    padv = v.padv; flush = v.flush; du = v.du; valid = v.valid; ops = v.ops;
    rf_wb = v.rf_wb; rfd = v.rfd; rfa = v.rfa; rfb = v.rfb;
    rfa_u = v.rfa_u; rfb_u = v.rfb_u; imm = v.imm; pc = v.pc; exc = v.exc;
  endtask

  // Drive one instruction with no sources, exceptions or flush.
  task automatic simple(input logic pv, input logic v, input logic [7:0] o,
                        input logic [31:0] p);
    padv = pv; flush = 1'b0; du = 1'b0; valid = v; ops = o; rf_wb = 1'b1;
    rfd = 5'd20; rfa = 5'd0; rfb = 5'd0; rfa_u = 1'b0; rfb_u = 1'b0;
    imm = 32'h0; pc = p; exc = 4'h0;
  endtask

  initial begin
    //       padv fl du v  ops    wb rfd    rfa   au rfb   bu imm       pc        exc
    //       stl  e_ops  ewb e_exc  bub cd e_rfd  e_imm     e_pc
    // normal advance
    vecs[0]  = mk(1,0,0,1, 8'h00, 1, 5'd3,  5'd1,1, 5'd0,0, 32'hFFFF, 32'h200, 4'h0,
                  0, 8'h00, 1, 4'h0, 0, 1, 5'd3,  32'hFFFF, 32'h200);
    // load enters execute (rfd 5)
    vecs[1]  = mk(1,0,0,1, 8'h01, 1, 5'd5,  5'd2,1, 5'd0,0, 32'h4,    32'h204, 4'h0,
                  0, 8'h01, 1, 4'h0, 0, 1, 5'd5,  32'h4,    32'h204);
    // load-use on rfa, no advance: stall visible, everything holds
    vecs[2]  = mk(0,0,0,1, 8'h00, 1, 5'd6,  5'd5,1, 5'd0,0, 32'h8,    32'h208, 4'h0,
                  1, 8'h01, 1, 4'h0, 0, 1, 5'd5,  32'h4,    32'h204);
    // same hazard with advance: bubble, pc held, imm/rfd still load
    vecs[3]  = mk(1,0,0,1, 8'h00, 1, 5'd6,  5'd5,1, 5'd0,0, 32'h8,    32'h208, 4'h0,
                  1, 8'h00, 0, 4'h0, 1, 1, 5'd6,  32'h8,    32'h204);
    // load gone: stalled instruction now advances
    vecs[4]  = mk(1,0,0,1, 8'h00, 1, 5'd6,  5'd5,1, 5'd0,0, 32'h8,    32'h208, 4'h0,
                  0, 8'h00, 1, 4'h0, 0, 1, 5'd6,  32'h8,    32'h208);
    // load (rfd 7)
    vecs[5]  = mk(1,0,0,1, 8'h01, 1, 5'd7,  5'd0,0, 5'd0,0, 32'h10,   32'h20C, 4'h0,
                  0, 8'h01, 1, 4'h0, 0, 1, 5'd7,  32'h10,   32'h20C);
    // hazard through rfb only (rfa matches but unused)
    vecs[6]  = mk(1,0,0,1, 8'h00, 1, 5'd8,  5'd7,0, 5'd7,1, 32'h20,   32'h210, 4'h0,
                  1, 8'h00, 0, 4'h0, 1, 1, 5'd8,  32'h20,   32'h20C);
    // load that does not write the register file (rfd 9)
    vecs[7]  = mk(1,0,0,1, 8'h01, 0, 5'd9,  5'd0,0, 5'd0,0, 32'h30,   32'h210, 4'h0,
                  0, 8'h01, 0, 4'h0, 0, 1, 5'd9,  32'h30,   32'h210);
    // reader of r9 sees no hazard; store with ibus_err+syscall
    vecs[8]  = mk(1,0,0,1, 8'h02, 0, 5'd10, 5'd9,1, 5'd9,1, 32'h40,   32'h214, 4'h5,
                  0, 8'h02, 0, 4'h5, 0, 1, 5'd10, 32'h40,   32'h214);
    // decode not valid: bubble, pc held
    vecs[9]  = mk(1,0,0,0, 8'h04, 1, 5'd11, 5'd0,0, 5'd0,0, 32'h50,   32'h218, 4'h2,
                  0, 8'h00, 0, 4'h0, 1, 1, 5'd11, 32'h50,   32'h214);
    // mtspr with trap
    vecs[10] = mk(1,0,0,1, 8'h08, 1, 5'd12, 5'd0,0, 5'd0,0, 32'h60,   32'h21C, 4'h8,
                  0, 8'h08, 1, 4'h8, 0, 1, 5'd12, 32'h60,   32'h21C);
    // flush under debug stall, no advance: outputs unchanged
    vecs[11] = mk(0,1,1,1, 8'h80, 1, 5'd1,  5'd0,0, 5'd0,0, 32'h99,   32'h300, 4'h2,
                  0, 8'h08, 1, 4'h8, 0, 1, 5'd12, 32'h60,   32'h21C);
    // flush beats advance
    vecs[12] = mk(1,1,0,1, 8'h80, 1, 5'd13, 5'd0,0, 5'd0,0, 32'h70,   32'h220, 4'h2,
                  0, 8'h00, 0, 4'h0, 1, 0, 5'd0,  32'h0,    32'h0);
    // flush under debug stall with advance: normal advance (rfe)
    vecs[13] = mk(1,1,1,1, 8'h40, 0, 5'd14, 5'd0,0, 5'd0,0, 32'h80,   32'h224, 4'h0,
                  0, 8'h40, 0, 4'h0, 0, 1, 5'd14, 32'h80,   32'h224);

    // ---- reset with advance requested ----
    simple(1'b1, 1'b1, 8'h01, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("reset bubble", 32'(q_bub), 32'h1);
    check("reset pc", q_pc, 32'h100);
    check("reset ops", 32'(q_ops), 32'h0);
    check("reset rf_wb", 32'(q_wb), 32'h0);
    check("reset exc", 32'(q_exc), 32'h0);
    check("reset delay_slot", 32'(q_ds), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- table ----
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d stall", i), 32'(q_stall), 32'(vecs[i].e_stall));
      @(posedge clk);
      #1;
      check($sformatf("v%0d ops", i), 32'(q_ops), 32'(vecs[i].e_ops));
      check($sformatf("v%0d rf_wb", i), 32'(q_wb), 32'(vecs[i].e_wb));
      check($sformatf("v%0d exc", i), 32'(q_exc), 32'(vecs[i].e_exc));
      check($sformatf("v%0d bubble", i), 32'(q_bub), 32'(vecs[i].e_bub));
      check($sformatf("v%0d delay_slot", i), 32'(q_ds), 32'h0);
      if (vecs[i].chk_data) begin
        check($sformatf("v%0d rfd", i), 32'(q_rfd), 32'(vecs[i].e_rfd));
        check($sformatf("v%0d imm", i), q_imm, vecs[i].e_imm);
        check($sformatf("v%0d pc", i), q_pc, vecs[i].e_pc);
      end
      @(negedge clk);
    end

    // ---- reset asserted while a load-use stall is held ----
    simple(1'b1, 1'b1, 8'h01, 32'h400);
    rfd = 5'd5;
    @(posedge clk); #1;
    check("mid-reset load in exec", 32'(q_ops), 32'h01);
    @(negedge clk);
    simple(1'b0, 1'b1, 8'h00, 32'h404);
    rfa = 5'd5; rfa_u = 1'b1;
    #1;
    check("mid-reset stall before", 32'(q_stall), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("mid-reset bubble", 32'(q_bub), 32'h1);
    check("mid-reset ops", 32'(q_ops), 32'h0);
    check("mid-reset pc", q_pc, 32'h100);
    check("mid-reset stall during", 32'(q_stall), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    padv = 1'b1;
    #1;
    check("post-reset stall", 32'(q_stall), 32'h0);
    @(posedge clk); #1;
    check("post-reset bubble", 32'(q_bub), 32'h0);
    check("post-reset pc", q_pc, 32'h404);
    check("post-reset rf_wb", 32'(q_wb), 32'h1);

    // ---- delay slot: jal, bubble, add (delay slot), add ----
    @(negedge clk);
    simple(1'b1, 1'b1, 8'h10, 32'h500);
    @(posedge clk); #1;
    check("ds jal", 32'(q_ds), 32'h0);
    check("ds jal op", 32'(q_ops), 32'h10);
    @(negedge clk);
    simple(1'b1, 1'b0, 8'h00, 32'h504);
    @(posedge clk); #1;
    check("ds bubble", 32'(q_ds), 32'h0);
    @(negedge clk);
    simple(1'b1, 1'b1, 8'h00, 32'h508);
    @(posedge clk); #1;
    check("ds slot add", 32'(q_ds), 32'(DS_EN));
    check("ds slot pc", q_pc, 32'h508);
    @(negedge clk);
    simple(1'b1, 1'b1, 8'h00, 32'h50C);
    @(posedge clk); #1;
    check("ds next add", 32'(q_ds), 32'h0);

    // ---- delay slot: branch, then flush clears tracking ----
    @(negedge clk);
    simple(1'b1, 1'b1, 8'h80, 32'h600);
    @(posedge clk); #1;
    @(negedge clk);
    simple(1'b0, 1'b1, 8'h00, 32'h604);
    flush = 1'b1;
    @(posedge clk); #1;
    check("ds flush", 32'(q_ds), 32'h0);
    check("ds flush bubble", 32'(q_bub), 32'h1);
    @(negedge clk);
    simple(1'b1, 1'b1, 8'h00, 32'h608);
    @(posedge clk); #1;
    check("ds after flush", 32'(q_ds), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100000");
    $fatal(1);
  end

endmodule : tb_mor1kx_decode_execute_cappuccino
`default_nettype wire
